// File: rtl/tff_seq_pkg.sv
// rtl/tff_seq_pkg.sv - shared op encodings and FSM states for the T-flip-flop sequencer
package tff_seq_pkg;

    localparam logic [1:0] OP_UP   = 2'b00;
    localparam logic [1:0] OP_DOWN = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_HOLD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/tff_bank.sv
// rtl/tff_bank.sv - bank of T flip-flops sharing one clock and synchronous reset
module tff_bank #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q
);

    // each bit toggles when its t is high and holds otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= q ^ t;
        end
    end

endmodule

// File: rtl/tff_count_seq.sv
// rtl/tff_count_seq.sv - command sequencer scheduling toggle enables for a T flip-flop bank
module tff_count_seq
    import tff_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] t_en,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             done,
    output logic             wrapped
);

    state_t           state;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] eff_len;
    logic             accept;
    logic [WIDTH-1:0] t_up;
    logic [WIDTH-1:0] t_dn;
    logic             carry_up;
    logic             carry_dn;

    // reset overrides everything, so the handshake is blocked while rst is high
    assign cmd_ready = (state == IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign done      = (state == DONE) && !rst;

    // LOAD always takes exactly one step; the other ops run for cmd_len steps
    assign eff_len = (cmd_op == OP_LOAD) ? LEN_W'(1) : cmd_len;

    // excitation: a bit toggles when all lower bits are ones (up) or zeros (down)
    always_comb begin
        t_up     = '0;
        t_dn     = '0;
        carry_up = 1'b1;
        carry_dn = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            t_up[i]  = carry_up;
            t_dn[i]  = carry_dn;
            carry_up = carry_up & q[i];
            carry_dn = carry_dn & ~q[i];
        end
        t_en = '0;
        tc   = 1'b0;
        if (state == RUN && !rst) begin
            case (op_q)
                OP_UP: begin
                    t_en = t_up;
                    tc   = &q;
                end
                OP_DOWN: begin
                    t_en = t_dn;
                    tc   = ~|q;
                end
                OP_LOAD: t_en = q ^ data_q;
                default: t_en = '0;
            endcase
        end
    end

    // command FSM with the remaining-step counter and sticky wrap flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= OP_UP;
            data_q    <= '0;
            remaining <= '0;
            wrapped   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q      <= cmd_op;
                        data_q    <= cmd_data;
                        remaining <= eff_len;
                        wrapped   <= 1'b0;
                        state     <= (eff_len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    remaining <= remaining - LEN_W'(1);
                    if (tc) begin
                        wrapped <= 1'b1;
                    end
                    if (remaining <= LEN_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    tff_bank #(
        .WIDTH(WIDTH)
    ) u_bank (
        .clk(clk),
        .rst(rst),
        .t  (t_en),
        .q  (q)
    );

endmodule

// File: tb/tb_tff_count_seq.sv
// tb/tb_tff_count_seq.sv - self-checking bench for tff_count_seq against a per-command timeline model
module tb_tff_count_seq;

    localparam int W  = 4;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [LW-1:0] cmd_len;
    logic [W-1:0]  cmd_data;
    logic [W-1:0]  t_en;
    logic [W-1:0]  q;
    logic          tc;
    logic          done;
    logic          wrapped;

    tff_count_seq #(
        .WIDTH(W),
        .LEN_W(LW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_len  (cmd_len),
        .cmd_data (cmd_data),
        .t_en     (t_en),
        .q        (q),
        .tc       (tc),
        .done     (done),
        .wrapped  (wrapped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] t_en;
        logic         tc;
        logic         done;
        logic         wrapped;
    } exp_t;

    exp_t         expq[$];
    logic [W-1:0] m_q;
    logic         m_wr;
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // expand one accepted command into the cycle-by-cycle outputs it must produce
    task automatic expand(input logic [1:0] op, input logic [LW-1:0] len, input logic [W-1:0] data);
        int           n_steps;
        logic [W-1:0] cur;
        logic [W-1:0] nxt;
        logic         wr;
        logic         t;
        n_steps = (op == 2'b10) ? 1 : int'(len);
        cur     = m_q;
        wr      = 1'b0;
        for (int n = 0; n < n_steps; n++) begin
            case (op)
                2'b00:   nxt = cur + 1'b1;
                2'b01:   nxt = cur - 1'b1;
                2'b10:   nxt = data;
                default: nxt = cur;
            endcase
            t = (op == 2'b00 && cur == {W{1'b1}}) || (op == 2'b01 && cur == '0);
            expq.push_back('{cur, cur ^ nxt, t, 1'b0, wr});
            wr  = wr | t;
            cur = nxt;
        end
        expq.push_back('{cur, {W{1'b0}}, 1'b0, 1'b1, wr});
        m_q  = cur;
        m_wr = wr;
    endtask

    // apply inputs for one cycle, check outputs against the model, then advance
    task automatic cyc(input logic r, input logic v, input logic [1:0] op,
                       input logic [LW-1:0] len, input logic [W-1:0] data);
        exp_t e;
        rst       = r;
        cmd_valid = v;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        #1;
        if (r) begin
            chk("rst_ready", 32'(cmd_ready), 32'(0));
            chk("rst_t_en", 32'(t_en), 32'(0));
            chk("rst_tc", 32'(tc), 32'(0));
            chk("rst_done", 32'(done), 32'(0));
            expq.delete();
            m_q  = '0;
            m_wr = 1'b0;
        end else if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("busy_ready", 32'(cmd_ready), 32'(0));
            chk("busy_q", 32'(q), 32'(e.q));
            chk("busy_t_en", 32'(t_en), 32'(e.t_en));
            chk("busy_tc", 32'(tc), 32'(e.tc));
            chk("busy_done", 32'(done), 32'(e.done));
            chk("busy_wrapped", 32'(wrapped), 32'(e.wrapped));
        end else begin
            chk("idle_ready", 32'(cmd_ready), 32'(1));
            chk("idle_q", 32'(q), 32'(m_q));
            chk("idle_t_en", 32'(t_en), 32'(0));
            chk("idle_tc", 32'(tc), 32'(0));
            chk("idle_done", 32'(done), 32'(0));
            chk("idle_wrapped", 32'(wrapped), 32'(m_wr));
            if (v) begin
                expand(op, len, data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_len   = '0;
        cmd_data  = '0;
        m_q       = '0;
        m_wr      = 1'b0;
        @(posedge clk);
        #1;

        // reset, then UP len=5
        cyc(1, 0, 2'b00, 8'd0, 4'h0);
        cyc(1, 1, 2'b00, 8'd3, 4'h0);
        cyc(0, 1, 2'b00, 8'd5, 4'h0);
        repeat (7) cyc(0, 0, 2'b00, 8'd0, 4'h0);

        // LOAD E then UP 3 through the wrap
        cyc(0, 1, 2'b10, 8'd9, 4'hE);
        repeat (2) cyc(0, 0, 2'b00, 8'd0, 4'h0);
        cyc(0, 1, 2'b00, 8'd3, 4'h0);
        repeat (5) cyc(0, 0, 2'b00, 8'd0, 4'h0);

        // LOAD 1 then DOWN 2 through zero
        cyc(0, 1, 2'b10, 8'd0, 4'h1);
        repeat (2) cyc(0, 0, 2'b00, 8'd0, 4'h0);
        cyc(0, 1, 2'b01, 8'd2, 4'h0);
        repeat (4) cyc(0, 0, 2'b00, 8'd0, 4'h0);

        // HOLD 4 with cmd_valid held high; the second accept lands in the first idle cycle
        cyc(0, 1, 2'b11, 8'd4, 4'h0);
        repeat (5) cyc(0, 1, 2'b00, 8'd1, 4'h0);
        cyc(0, 1, 2'b01, 8'd1, 4'h0);
        repeat (3) cyc(0, 0, 2'b00, 8'd0, 4'h0);

        // zero-length UP, then LOAD 7
        cyc(0, 1, 2'b00, 8'd0, 4'h0);
        cyc(0, 0, 2'b00, 8'd0, 4'h0);
        cyc(0, 1, 2'b10, 8'd0, 4'h7);
        repeat (3) cyc(0, 0, 2'b00, 8'd0, 4'h0);

        // UP 10 aborted by rst in the third RUN cycle
        cyc(0, 1, 2'b00, 8'd10, 4'h0);
        repeat (2) cyc(0, 0, 2'b00, 8'd0, 4'h0);
        cyc(1, 0, 2'b00, 8'd0, 4'h0);
        repeat (3) cyc(0, 0, 2'b00, 8'd0, 4'h0);

        // randomized commands, gaps and occasional resets
        for (int it = 0; it < 300; it++) begin
            logic          r;
            logic          v;
            logic [1:0]    op;
            logic [LW-1:0] len;
            logic [W-1:0]  data;
            r    = ($urandom_range(0, 39) == 0);
            v    = ($urandom_range(0, 2) != 0);
            op   = 2'($urandom_range(0, 3));
            len  = LW'($urandom_range(0, 20));
            data = W'($urandom);
            cyc(r, v, op, len, data);
        end
        repeat (25) cyc(0, 0, 2'b00, 8'd0, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tff_count_seq.md
# tff_count_seq

Command-driven sequencer that owns a bank of T flip-flops and schedules their per-bit toggle enables to count up, count down, load or hold for a programmed number of clock cycles. It is the control layer above the T-flip-flop datapath: requesters issue single commands over a valid/ready handshake, and the block reports completion and wrap-around. It replaces ad-hoc JK/T excitation logic scattered across callers.

## Interface
Parameters:
- WIDTH, 4: number of T flip-flops in the bank (counter width); legal range 2..16.
- LEN_W, 8: width of the step-count field.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  operation: 00 UP, 01 DOWN, 10 LOAD, 11 HOLD.
- cmd_len  in  LEN_W  number of steps; ignored for LOAD.
- cmd_data  in  WIDTH  load value; used by LOAD only.
- t_en  out  WIDTH  toggle vector driven into the bank this cycle.
- q  out  WIDTH  bank state.
- tc  out  1  current step wraps the counter.
- done  out  1  one-cycle completion pulse.
- wrapped  out  1  at least one wrap occurred during the last command.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - cmd_ready=1 and t_en=0.
  - Accept on cmd_valid&&cmd_ready. Latch op, data and len into a remaining-step counter; clear wrapped.
  - Next state is RUN, or DONE if the effective length is 0.
- Effective length:
  - LOAD is always 1.
  - UP, DOWN and HOLD use cmd_len. A value of 0 completes with no steps.
- RUN, one step per cycle:
  - t_en is combinational from the latched op and the current q.
  - UP: t_en[0]=1, t_en[i]=&q[i-1:0]. All-ones wraps to 0.
  - DOWN: t_en[0]=1, t_en[i]=&~q[i-1:0]. 0 wraps to all-ones.
  - LOAD: t_en=q^data. At the end of the cycle q equals data.
  - HOLD: t_en=0.
  - remaining decrements each cycle. Leave RUN for DONE after the cycle in which remaining==1.
- tc=1 only in RUN when (UP and q all-ones) or (DOWN and q zero). A cycle with tc=1 sets wrapped at that edge.
- DONE lasts one cycle with done=1 and cmd_ready=0, then goes to IDLE. wrapped holds its value until the next accept.
- cmd_ready=0 in RUN and DONE. cmd_valid in those states is ignored and is not queued.

## Timing
- Accept at edge k. RUN occupies cycles k+1..k+L. DONE is cycle k+L+1. cmd_ready returns in cycle k+L+2.
- q updates at the edge ending each RUN cycle, so the value of q after step n is visible in cycle k+n+1.
- For L=0, DONE is cycle k+1.
- Back-to-back: a new command can be accepted in the first IDLE cycle, so there is a 2-cycle minimum gap between commands.
- Reset values while rst=1 and on the following cycle:
  - state=IDLE, q=0, remaining=0, t_en=0, tc=0, done=0, wrapped=0.
  - cmd_ready=0 while rst=1 and 1 from the first cycle after rst is released.
- rst mid-RUN or in DONE aborts the command: no done pulse, and q is forced to 0.
- rst has priority over every other event, including an accept in the same cycle.

## Structure
- Package tff_seq_pkg holds:
  - the op encodings OP_UP=2'b00, OP_DOWN=2'b01, OP_LOAD=2'b10, OP_HOLD=2'b11;
  - the state enum (IDLE, RUN, DONE).
- Sub-module tff_bank: WIDTH T flip-flops with a shared clk and synchronous active-high rst. Inputs t[WIDTH-1:0], output q. A bit toggles when its t=1 and holds otherwise.
- tff_count_seq contains the FSM, the remaining-step counter, the t_en excitation logic and the tc/wrapped logic.

## Test plan
All scenarios use WIDTH=4.
1. After rst, UP len=5 -> q steps 1,2,3,4,5 in consecutive cycles; done in cycle k+6; wrapped=0; tc never high.
2. LOAD data=4'hE, then UP len=3 -> q=E after the load; then F, 0, 1; tc=1 in the cycle where q=F; wrapped=1 at done.
3. From q=1, DOWN len=2 -> q goes 0 then F; tc=1 in the cycle where q=0; wrapped=1.
4. HOLD len=4 with cmd_valid held high throughout -> t_en=0 and q unchanged for 4 cycles; cmd_ready=0 and no second accept until cycle k+6.
5. UP len=0 -> done in cycle k+1; q unchanged; wrapped=0. Then LOAD data=4'h7 -> q=7 and done one cycle later.
6. UP len=10 with rst pulsed during the third RUN cycle -> q=0, state IDLE, no done pulse; cmd_ready=1 on the cycle after rst drops.
